// File: rtl/pixel_readout_pkg.sv
// Shared widths, the FIFO entry layout and the pixel-select helper for the
// pixel readout capture block.
package pixel_readout_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              sof;
    logic              eol;
    logic              eof;
  } pix_word_entry_t;

  // Phase 0 carries the even column (upper byte), phase 1 the odd column.
  function automatic logic [PIX_W-1:0] select_pixel(input pix_word_entry_t e,
                                                    input logic phase);
    return phase ? e.word[PIX_W-1:0] : e.word[WORD_W-1:PIX_W];
  endfunction

endpackage

// File: rtl/pixel_readout_capture_if.sv
// Readout word input and tagged pixel stream output of the capture block.
interface pixel_readout_capture_if;
  import pixel_readout_pkg::*;

  logic              word_valid;
  logic [WORD_W-1:0] pixel_word;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output word_valid, pixel_word, pix_ready,
    input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof
  );

  modport slave (
    input  word_valid, pixel_word, pix_ready,
    output pix_valid, pix_data, pix_sof, pix_eol, pix_eof
  );

endinterface

// File: rtl/pixel_word_fifo.sv
// Show-ahead synchronous FIFO of tagged readout words; a push into a full
// FIFO is taken only when a pop happens in the same cycle.
module pixel_word_fifo
  import pixel_readout_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  pix_word_entry_t          push_data,
  input  logic                     pop,
  output pix_word_entry_t          head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  pix_word_entry_t   mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       level_r;
  logic              do_pop_s;
  logic              do_push_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == {(AW+1){1'b0}});
  assign level     = level_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Entry storage; contents are qualified by level so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset && do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1'b1);
        2'b01:   level_r <= level_r - (AW+1)'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/pixel_readout_capture.sv
// Receive end of the pixel readout bus: tags 16-bit readout words with frame
// position, buffers them and serialises them into an 8-bit pixel stream.
module pixel_readout_capture
  import pixel_readout_pkg::*;
#(
  parameter int N_COLS     = 4,
  parameter int N_ROWS     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          clr_overflow,
  pixel_readout_capture_if.slave        bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int WPR   = N_COLS / 2;
  localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WPR - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  logic [COL_W-1:0] word_col_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] cur_col_s;
  logic [ROW_W-1:0] cur_row_s;
  logic [COL_W-1:0] nxt_col_s;
  logic [ROW_W-1:0] nxt_row_s;
  logic             phase_r;
  logic             overflow_r;
  logic             full_s;
  logic             empty_s;
  logic             xfer_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  pix_word_entry_t  entry_s;
  pix_word_entry_t  head_s;

  // frame_start realigns the position used for this cycle's word.
  always_comb begin
    cur_col_s = word_col_r;
    cur_row_s = row_r;
    if (frame_start) begin
      cur_col_s = {COL_W{1'b0}};
      cur_row_s = {ROW_W{1'b0}};
    end else begin
      cur_col_s = word_col_r;
      cur_row_s = row_r;
    end
  end

  // Position following the current word, wrapping row then frame.
  always_comb begin
    nxt_col_s = cur_col_s;
    nxt_row_s = cur_row_s;
    if (cur_col_s == LAST_COL) begin
      nxt_col_s = {COL_W{1'b0}};
      if (cur_row_s == LAST_ROW) begin
        nxt_row_s = {ROW_W{1'b0}};
      end else begin
        nxt_row_s = cur_row_s + ROW_W'(1'b1);
      end
    end else begin
      nxt_col_s = cur_col_s + COL_W'(1'b1);
      nxt_row_s = cur_row_s;
    end
  end

  // Tags are fixed when the word enters the FIFO.
  always_comb begin
    entry_s.word = bus.pixel_word;
    entry_s.sof  = (cur_row_s == {ROW_W{1'b0}}) && (cur_col_s == {COL_W{1'b0}});
    entry_s.eol  = (cur_col_s == LAST_COL);
    entry_s.eof  = (cur_col_s == LAST_COL) && (cur_row_s == LAST_ROW);
  end

  assign xfer_s = !empty_s && bus.pix_ready;
  assign pop_s  = xfer_s && phase_r;
  assign push_s = bus.word_valid && (!full_s || pop_s);
  assign drop_s = bus.word_valid && !push_s;

  // Position counters advance on every word, dropped or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_col_r <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
    end else if (bus.word_valid) begin
      word_col_r <= nxt_col_s;
      row_r      <= nxt_row_s;
    end else if (frame_start) begin
      word_col_r <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  // Serialiser phase: even column first, odd column pops the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r <= 1'b0;
    end else if (xfer_s) begin
      phase_r <= !phase_r;
    end
  end

  pixel_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  assign overflow      = overflow_r;
  assign bus.pix_valid = !empty_s;
  assign bus.pix_data  = empty_s ? {PIX_W{1'b0}} : select_pixel(head_s, phase_r);
  assign bus.pix_sof   = !empty_s && !phase_r && head_s.sof;
  assign bus.pix_eol   = !empty_s &&  phase_r && head_s.eol;
  assign bus.pix_eof   = !empty_s &&  phase_r && head_s.eof;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Scoreboard bench for pixel_readout_capture: a pixel-queue reference model
// predicts the stream, a negedge monitor compares every presented pixel.
module tb_pixel_readout_capture;
  import pixel_readout_pkg::*;

  localparam int N_COLS = 4;
  localparam int N_ROWS = 2;
  localparam int DEPTH  = 8;
  localparam int WPR    = N_COLS / 2;
  localparam int FRAME_WORDS = WPR * N_ROWS;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [3:0] fifo_level;
  logic       overflow;

  pixel_readout_capture_if bus();

  pixel_readout_capture #(
    .N_COLS     (N_COLS),
    .N_ROWS     (N_ROWS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .clr_overflow (clr_overflow),
    .bus          (bus.slave),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  exp_pix_t sb_q[$];
  int       mdl_pix = 0;   // pixels held by the DUT
  int       mdl_wpos = 0;  // word index within the frame
  bit       mdl_ovf = 1'b0;
  bit       started = 1'b0;
  int       errors = 0;
  int       checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated with the inputs present at each rising edge.
  initial begin
    forever begin
      int  p;
      bit  tx, pop, full, acc;
      exp_pix_t e0, e1;
      @(posedge clk);
      if (reset) begin
        sb_q.delete();
        mdl_pix  = 0;
        mdl_wpos = 0;
        mdl_ovf  = 1'b0;
        started  = 1'b1;
      end else begin
        tx   = bus.pix_ready && (mdl_pix > 0);
        pop  = tx && (mdl_pix % 2 == 1);
        full = ((mdl_pix + 1) / 2) >= DEPTH;
        acc  = bus.word_valid && (!full || pop);
        p    = frame_start ? 0 : mdl_wpos;
        if (bus.word_valid) begin
          if (acc) begin
            e0.d = bus.pixel_word[15:8]; e0.sof = (p == 0); e0.eol = 1'b0; e0.eof = 1'b0;
            e1.d = bus.pixel_word[7:0];  e1.sof = 1'b0;
            e1.eol = ((p % WPR) == WPR - 1);
            e1.eof = (p == FRAME_WORDS - 1);
            sb_q.push_back(e0);
            sb_q.push_back(e1);
          end else begin
            mdl_ovf = 1'b1;
          end
          mdl_wpos = (p + 1) % FRAME_WORDS;
        end else if (frame_start) begin
          mdl_wpos = 0;
        end
        if (clr_overflow && !(bus.word_valid && !acc)) mdl_ovf = 1'b0;
        mdl_pix = mdl_pix - (tx ? 1 : 0) + (acc ? 2 : 0);
      end
    end
  end

  // Monitor: compares the presented pixel and status away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("pix_valid", {31'd0, bus.pix_valid}, {31'd0, mdl_pix > 0});
        chk("fifo_level", {28'd0, fifo_level}, (mdl_pix + 1) / 2);
        chk("overflow", {31'd0, overflow}, {31'd0, mdl_ovf});
        if (bus.pix_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_pixel", {21'd0, bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_eof}, 32'hFFFF_FFFF);
          end else begin
            chk("pixel", {21'd0, bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_eof},
                {21'd0, sb_q[0].d, sb_q[0].sof, sb_q[0].eol, sb_q[0].eof});
            if (bus.pix_ready) void'(sb_q.pop_front());
          end
        end else begin
          chk("idle_outputs", {21'd0, bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_eof}, 32'd0);
        end
      end
    end
  end

  task automatic drive(input bit fs, input bit wv, input logic [15:0] w,
                       input bit rdy, input bit clr, input bit rst);
    @(posedge clk);
    #2;
    frame_start    = fs;
    bus.word_valid = wv;
    bus.pixel_word = w;
    bus.pix_ready  = rdy;
    clr_overflow   = clr;
    reset          = rst;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    bus.word_valid = 1'b0;
    bus.pixel_word = 16'h0000;
    bus.pix_ready  = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Basic frame with downstream always ready.
    drive(1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);

    // Fill, drop the ninth word, clear, then push while the full FIFO pops.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 16'h4000 + 16'(i * 16'h0101), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    idle(20, 1'b1);

    // Stall pattern 1,0,0,1 across one word.
    idle(1, 1'b0);
    drive(1'b0, 1'b1, 16'h5A3C, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // frame_start mid-row with a concurrent word.
    drive(1'b0, 1'b1, 16'h0102, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h7E7E, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0, 1'b0);
    idle(12, 1'b1);

    // Reset with three words queued and the serialiser in phase 1.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'hC3C3, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 40) == 0, ($urandom % 3) != 0, 16'($urandom),
            ($urandom % 4) != 0, ($urandom % 30) == 0, ($urandom % 200) == 0);
    end
    idle(40, 1'b1);
    @(negedge clk);
    chk("drain_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_readout_capture.md
Name: pixel_readout_capture

Overview:
- Receive end of the pixel readout bus: accepts the registered 16-bit readout words produced during the sensor READ phases and turns them into a tagged 8-bit pixel stream.
- Each word carries two 8-bit ADC samples, taken from the two duplicated ramp bytes: [15:8] is the even column and [7:0] is the odd column.
- Words are buffered in a small FIFO, then serialised to a valid/ready pixel stream with frame and row tags for the downstream frame buffer.

Parameters:
- N_COLS, 4, pixels per row; must be even and >= 2.
- N_ROWS, 2, rows per frame; >= 1.
- FIFO_DEPTH, 8, word entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_start  input  1  one-cycle pulse; resynchronises position counters to row 0, col 0
- word_valid  input  1  pixel_word is valid this cycle; no backpressure upstream
- pixel_word  input  16  two packed pixel samples, [15:8] then [7:0]
- clr_overflow  input  1  clears the sticky overflow flag
- pix_valid  output  1  output pixel valid
- pix_ready  input  1  downstream accepts the pixel
- pix_data  output  8  pixel sample
- pix_sof  output  1  first pixel of frame (row 0, col 0)
- pix_eol  output  1  last pixel of a row (col N_COLS-1)
- pix_eof  output  1  last pixel of frame (row N_ROWS-1, col N_COLS-1)
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently stored
- overflow  output  1  sticky: at least one word was dropped

Behaviour:
- Reset (synchronous, active-high): FIFO empty, counters 0, serialiser phase 0, all outputs 0.
  - Reset wins over every other input in the same cycle.
  - A stream transfer in progress is abandoned and is not completed after reset.
- Position tracking:
  - word_col counts words within a row, 0..N_COLS/2-1; row counts 0..N_ROWS-1.
  - Each word_valid advances word_col, including dropped words, so tags stay aligned to the sensor.
  - When word_col wraps, row increments; when row also wraps, both return to 0.
- frame_start:
  - Forces the counters to 0 for the current cycle's tag computation.
  - If word_valid is high in the same cycle, that word is tagged as row 0, word 0, and the counters move to word 1 afterwards.
- Tag computation at write time. Each FIFO entry holds word[15:0], sof, eol, eof:
  - sof = (row==0 && word_col==0).
  - eol = (word_col==N_COLS/2-1).
  - eof = eol && row==N_ROWS-1.
- FIFO write:
  - A word is written when word_valid && (!full || pop_this_cycle).
  - Otherwise the word is dropped and overflow is set to 1.
  - overflow holds until reset or clr_overflow. If clr_overflow and a new drop occur in the same cycle, the drop wins (overflow stays 1).
- Serialiser, a phase bit over the FIFO head:
  - phase 0 presents pix_data=head[15:8] with pix_sof=head.sof, pix_eol=0, pix_eof=0.
  - phase 1 presents pix_data=head[7:0] with pix_sof=0, pix_eol=head.eol, pix_eof=head.eof.
- Transfer rules:
  - A transfer occurs on pix_valid && pix_ready.
  - In phase 0 a transfer sets phase 1. In phase 1 a transfer pops the head (pop_this_cycle) and sets phase 0.
  - pix_valid = !empty.
  - pix_data and the tags are stable while pix_valid && !pix_ready.
- Latency: a word written at clock edge N makes pix_valid high in cycle N+1 if the FIFO was empty, so the first pixel appears 1 cycle after acceptance.
- Simultaneous push and pop are allowed at any level; fifo_level is unchanged in that case.
- Full throughput is one pixel per cycle. A word every cycle therefore fills the FIFO; this is the intended overflow case.

Decomposition:
- Package pixel_readout_pkg holds:
  - PIX_W=8 and WORD_W=16.
  - Typedef struct pix_word_entry_t {word, sof, eol, eof}.
- Sub-module pixel_word_fifo:
  - Synchronous FIFO of pix_word_entry_t, parameterised by DEPTH.
  - Show-ahead head, full/empty/level outputs, push-when-full-with-pop allowed.
- Counters, tag logic, overflow flag and serialiser live in pixel_readout_capture.

Test Plan:
- Reset, then frame_start plus 4 words (0xA5A5, 0x1111, 0x2222, 0x3333) with pix_ready=1 -> pixels A5,A5,11,11,22,22,33,33.
  - sof on pixel 0 only; eol on pixels 3 and 7; eof on pixel 7 only; fifo_level returns to 0.
- 8 words pushed with pix_ready=0 -> fifo_level=8, overflow=0; a 9th word -> dropped, overflow=1, fifo_level=8.
  - Raise pix_ready -> the 16 pixels of the first 8 words emerge in order; the dropped word never appears.
- FIFO full, with pix_ready=1 while phase 1 pops, and word_valid=1 in the same cycle -> word accepted, overflow stays 0, fifo_level stays 8.
- pix_ready toggled 1,0,0,1 during one word -> pix_data and the tags are held unchanged across the stall cycles and no pixel is duplicated.
- frame_start mid-row (after 1 word) with a concurrent word 0x7E7E -> that word's first pixel carries pix_sof=1, and the next frame's tags are realigned.
- Reset asserted with 3 words queued and phase=1 -> next cycle pix_valid=0, fifo_level=0, overflow=0.
  - A subsequent word is tagged sof=1.
